// File: rtl/vx_gpr_bank_arbiter_if.sv
// Collector/bank-side bus of the GPR bank arbiter: request/grant, bank read ports, responses.
// The master side is the surrounding collectors plus the bank RAMs.
interface vx_gpr_bank_arbiter_if #(
  parameter int NUM_REQS  = 4,
  parameter int NUM_BANKS = 4,
  parameter int ADDR_W    = 10,
  parameter int OPD_ID_W  = 2,
  parameter int DATAW     = 128,
  parameter int BSEL_W    = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 0,
  parameter int BADDR_W   = ADDR_W - BSEL_W
);
  logic [NUM_REQS-1:0]           req_valid;
  logic [NUM_REQS*ADDR_W-1:0]    req_addr;
  logic [NUM_REQS*OPD_ID_W-1:0]  req_opd_id;
  logic [NUM_REQS-1:0]           req_ready;
  logic [NUM_BANKS-1:0]          bank_rd_en;
  logic [NUM_BANKS*BADDR_W-1:0]  bank_rd_addr;
  logic [NUM_BANKS*DATAW-1:0]    bank_rd_data;
  logic [NUM_REQS-1:0]           rsp_valid;
  logic [NUM_REQS*OPD_ID_W-1:0]  rsp_opd_id;
  logic [NUM_REQS*DATAW-1:0]     rsp_data;

  modport master (
    output req_valid, req_addr, req_opd_id, bank_rd_data,
    input  req_ready, bank_rd_en, bank_rd_addr, rsp_valid, rsp_opd_id, rsp_data
  );

  modport slave (
    input  req_valid, req_addr, req_opd_id, bank_rd_data,
    output req_ready, bank_rd_en, bank_rd_addr, rsp_valid, rsp_opd_id, rsp_data
  );
endinterface

// File: rtl/vx_gpr_bank_arbiter.sv
// Routes operand-collector register reads to GPR banks with per-bank round-robin arbitration
// and returns tagged read data READ_LATENCY cycles after the grant.
module vx_gpr_bank_arbiter #(
  parameter int NUM_REQS     = 4,
  parameter int NUM_BANKS    = 4,
  parameter int ADDR_W       = 10,
  parameter int OPD_ID_W     = 2,
  parameter int DATAW        = 128,
  parameter int READ_LATENCY = 1
) (
  input  logic                clk,
  input  logic                reset,
  vx_gpr_bank_arbiter_if.slave bus,
  output logic [31:0]         perf_conflicts
);
  localparam int BSEL_W  = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 0;
  localparam int BADDR_W = ADDR_W - BSEL_W;
  localparam int RID_W   = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1;
  localparam int BIDX_W  = (BSEL_W > 0) ? BSEL_W : 1;
  localparam int TAIL    = READ_LATENCY - 1;

  function automatic logic [RID_W-1:0] rr_idx(input logic [RID_W-1:0] base, input int unsigned off);
    return RID_W'((32'(base) + off) % NUM_REQS);
  endfunction

  logic [BIDX_W-1:0]   req_bank  [NUM_REQS];
  logic [BADDR_W-1:0]  req_baddr [NUM_REQS];
  logic [OPD_ID_W-1:0] req_opd   [NUM_REQS];
  logic [DATAW-1:0]    bank_data [NUM_BANKS];

  for (genvar i = 0; i < NUM_REQS; i++) begin : g_req
    assign req_baddr[i] = bus.req_addr[i*ADDR_W+BSEL_W +: BADDR_W];
    assign req_opd[i]   = bus.req_opd_id[i*OPD_ID_W +: OPD_ID_W];
    if (BSEL_W > 0) begin : g_bsel
      assign req_bank[i] = bus.req_addr[i*ADDR_W +: BIDX_W];
    end else begin : g_nobsel
      assign req_bank[i] = '0;
    end
  end

  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank_data
    assign bank_data[b] = bus.bank_rd_data[b*DATAW +: DATAW];
  end

  logic [RID_W-1:0]    ptr_q     [NUM_BANKS];
  logic [NUM_REQS-1:0] cand      [NUM_BANKS];
  logic [NUM_BANKS-1:0] bank_multi;
  logic [NUM_BANKS-1:0] grant_en;
  logic [RID_W-1:0]    grant_rid [NUM_BANKS];
  logic [OPD_ID_W-1:0] grant_opd [NUM_BANKS];
  logic [BADDR_W-1:0]  bank_addr_c [NUM_BANKS];
  logic [NUM_REQS-1:0] ready_c;

  always_comb begin
    for (int unsigned b = 0; b < NUM_BANKS; b++) begin
      cand[b] = '0;
      for (int unsigned i = 0; i < NUM_REQS; i++) begin
        cand[b][i] = bus.req_valid[i] && (req_bank[i] == BIDX_W'(b));
      end
      bank_multi[b] = (cand[b] & (cand[b] - 1'b1)) != '0;
    end
  end

  // First candidate found walking upward from ptr wins; reset suppresses every grant.
  always_comb begin
    grant_en = '0;
    for (int unsigned b = 0; b < NUM_BANKS; b++) begin
      grant_rid[b] = '0;
      for (int unsigned k = 0; k < NUM_REQS; k++) begin
        if (!reset && !grant_en[b] && cand[b][rr_idx(ptr_q[b], k)]) begin
          grant_en[b]  = 1'b1;
          grant_rid[b] = rr_idx(ptr_q[b], k);
        end
      end
      grant_opd[b]   = req_opd[grant_rid[b]];
      bank_addr_c[b] = grant_en[b] ? req_baddr[grant_rid[b]] : '0;
    end
  end

  always_comb begin
    ready_c = '0;
    for (int unsigned i = 0; i < NUM_REQS; i++) begin
      for (int unsigned b = 0; b < NUM_BANKS; b++) begin
        if (grant_en[b] && grant_rid[b] == RID_W'(i)) ready_c[i] = 1'b1;
      end
    end
  end

  assign bus.req_ready  = ready_c;
  assign bus.bank_rd_en = grant_en;
  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank_addr
    assign bus.bank_rd_addr[b*BADDR_W +: BADDR_W] = bank_addr_c[b];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned b = 0; b < NUM_BANKS; b++) ptr_q[b] <= '0;
      perf_conflicts <= '0;
    end else begin
      for (int unsigned b = 0; b < NUM_BANKS; b++) begin
        if (grant_en[b]) ptr_q[b] <= rr_idx(grant_rid[b], 1);
      end
      if (|bank_multi && perf_conflicts != '1) perf_conflicts <= perf_conflicts + 32'd1;
    end
  end

  logic                pipe_valid [NUM_BANKS][READ_LATENCY];
  logic [RID_W-1:0]    pipe_rid   [NUM_BANKS][READ_LATENCY];
  logic [OPD_ID_W-1:0] pipe_opd   [NUM_BANKS][READ_LATENCY];

  // Only valid bits are cleared on reset; rid/opd are qualified by valid.
  always_ff @(posedge clk) begin
    for (int unsigned b = 0; b < NUM_BANKS; b++) begin
      pipe_valid[b][0] <= grant_en[b];
      pipe_rid[b][0]   <= grant_rid[b];
      pipe_opd[b][0]   <= grant_opd[b];
      for (int unsigned s = 1; s < READ_LATENCY; s++) begin
        pipe_valid[b][s] <= pipe_valid[b][s-1] && !reset;
        pipe_rid[b][s]   <= pipe_rid[b][s-1];
        pipe_opd[b][s]   <= pipe_opd[b][s-1];
      end
    end
  end

  logic [NUM_REQS-1:0] rsp_valid_c;
  logic [OPD_ID_W-1:0] rsp_opd_c  [NUM_REQS];
  logic [DATAW-1:0]    rsp_data_c [NUM_REQS];

  always_comb begin
    rsp_valid_c = '0;
    for (int unsigned r = 0; r < NUM_REQS; r++) begin
      rsp_opd_c[r]  = '0;
      rsp_data_c[r] = '0;
    end
    for (int unsigned b = 0; b < NUM_BANKS; b++) begin
      if (pipe_valid[b][TAIL]) begin
        rsp_valid_c[pipe_rid[b][TAIL]] = 1'b1;
        rsp_opd_c[pipe_rid[b][TAIL]]   = pipe_opd[b][TAIL];
        rsp_data_c[pipe_rid[b][TAIL]]  = bank_data[b];
      end
    end
  end

  assign bus.rsp_valid = rsp_valid_c;
  for (genvar r = 0; r < NUM_REQS; r++) begin : g_rsp
    assign bus.rsp_opd_id[r*OPD_ID_W +: OPD_ID_W] = rsp_opd_c[r];
    assign bus.rsp_data[r*DATAW +: DATAW]         = rsp_data_c[r];
  end
endmodule

// File: tb/tb_vx_gpr_bank_arbiter.sv
// Bench for vx_gpr_bank_arbiter: one instance at READ_LATENCY=1, one at READ_LATENCY=3,
// each fed by a delay-line bank RAM model; expected responses go through per-instance queues.
module tb_vx_gpr_bank_arbiter;
  localparam int NR = 4, NB = 4, AW = 10, OW = 2, DW = 128, BAW = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_a, reset_b;
  logic [31:0] perf_a, perf_b;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  vx_gpr_bank_arbiter_if #(.NUM_REQS(NR), .NUM_BANKS(NB), .ADDR_W(AW), .OPD_ID_W(OW), .DATAW(DW)) ifa ();
  vx_gpr_bank_arbiter_if #(.NUM_REQS(NR), .NUM_BANKS(NB), .ADDR_W(AW), .OPD_ID_W(OW), .DATAW(DW)) ifb ();

  vx_gpr_bank_arbiter #(.NUM_REQS(NR), .NUM_BANKS(NB), .ADDR_W(AW), .OPD_ID_W(OW), .DATAW(DW),
                        .READ_LATENCY(1)) u_dut_a (
    .clk(clk), .reset(reset_a), .bus(ifa.slave), .perf_conflicts(perf_a));

  vx_gpr_bank_arbiter #(.NUM_REQS(NR), .NUM_BANKS(NB), .ADDR_W(AW), .OPD_ID_W(OW), .DATAW(DW),
                        .READ_LATENCY(3)) u_dut_b (
    .clk(clk), .reset(reset_b), .bus(ifb.slave), .perf_conflicts(perf_b));

  // Bank RAM contents are a fixed function of bank and bank-local address.
  function automatic logic [DW-1:0] mkdata(input int b, input logic [BAW-1:0] a);
    return {8'(b), a, 16'hC0DE, 32'(a) * 32'h9E37_79B9, 64'h0123_4567_89AB_CDEF ^ {56'd0, a}};
  endfunction

  logic [BAW-1:0] ram_a [NB];
  logic [BAW-1:0] ram_b [NB][3];
  always @(posedge clk) begin
    for (int b = 0; b < NB; b++) begin
      ram_a[b]    <= ifa.bank_rd_addr[b*BAW +: BAW];
      ram_b[b][0] <= ifb.bank_rd_addr[b*BAW +: BAW];
      ram_b[b][1] <= ram_b[b][0];
      ram_b[b][2] <= ram_b[b][1];
    end
  end
  for (genvar b = 0; b < NB; b++) begin : g_ram
    assign ifa.bank_rd_data[b*DW +: DW] = mkdata(b, ram_a[b]);
    assign ifb.bank_rd_data[b*DW +: DW] = mkdata(b, ram_b[b][2]);
  end

  typedef struct {
    int            rid;
    logic [OW-1:0] opd;
    logic [DW-1:0] data;
    int            due;
  } exp_t;
  exp_t qa[$];
  exp_t qb[$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_reqs();
    ifa.req_valid = '0; ifa.req_addr = '0; ifa.req_opd_id = '0;
    ifb.req_valid = '0; ifb.req_addr = '0; ifb.req_opd_id = '0;
  endtask

  task automatic set_req(input bit on_b, input int i, input logic [AW-1:0] addr, input logic [OW-1:0] opd);
    if (on_b) begin
      ifb.req_valid[i] = 1'b1; ifb.req_addr[i*AW +: AW] = addr; ifb.req_opd_id[i*OW +: OW] = opd;
    end else begin
      ifa.req_valid[i] = 1'b1; ifa.req_addr[i*AW +: AW] = addr; ifa.req_opd_id[i*OW +: OW] = opd;
    end
  endtask

  task automatic test_reset();
    reset_a = 1'b1; reset_b = 1'b1;
    for (int i = 0; i < NR; i++) begin
      set_req(0, i, AW'(i), OW'(i));
      set_req(1, i, AW'(i), OW'(i));
    end
    for (int c = 0; c < 3; c++) begin
      tick(); #2;
      checks++;
      if (ifa.req_ready !== 4'b0000 || ifa.bank_rd_en !== 4'b0000) begin
        errors++; $display("FAIL reset_gate_a: ready=%b rd_en=%b, expected 0000/0000", ifa.req_ready, ifa.bank_rd_en);
      end
      checks++;
      if (ifb.req_ready !== 4'b0000 || ifb.bank_rd_en !== 4'b0000) begin
        errors++; $display("FAIL reset_gate_b: ready=%b rd_en=%b, expected 0000/0000", ifb.req_ready, ifb.bank_rd_en);
      end
    end
    tick();
    reset_a = 1'b0; reset_b = 1'b0;
    clear_reqs();
    #2;
    checks++;
    if (perf_a !== 32'd0 || perf_b !== 32'd0) begin
      errors++; $display("FAIL reset_perf: a=%0d b=%0d, expected 0/0", perf_a, perf_b);
    end
    checks++;
    if (ifa.rsp_valid !== 4'b0000 || ifb.rsp_valid !== 4'b0000) begin
      errors++; $display("FAIL reset_rsp: a=%b b=%b, expected 0000/0000", ifa.rsp_valid, ifb.rsp_valid);
    end
    tick();
  endtask

  task automatic test_single();
    logic [NR-1:0] exp_v;
    exp_t e;
    for (int c = 0; c < 2; c++) begin
      clear_reqs();
      if (c == 0) set_req(0, 0, 10'h005, 2'd2);
      #2;
      exp_v = '0;
      while (qa.size() > 0 && qa[0].due == cyc) begin
        e = qa.pop_front();
        exp_v[e.rid] = 1'b1;
        checks++;
        if (ifa.rsp_opd_id[e.rid*OW +: OW] !== e.opd || ifa.rsp_data[e.rid*DW +: DW] !== e.data) begin
          errors++; $display("FAIL single_rsp r%0d: opd=%0d data=%h, expected opd=%0d data=%h", e.rid,
                             ifa.rsp_opd_id[e.rid*OW +: OW], ifa.rsp_data[e.rid*DW +: DW], e.opd, e.data);
        end
      end
      checks++;
      if (ifa.rsp_valid !== exp_v) begin
        errors++; $display("FAIL single_rsp_valid: got %b, expected %b", ifa.rsp_valid, exp_v);
      end
      if (c == 0) begin
        checks++;
        if (ifa.req_ready !== 4'b0001 || ifa.bank_rd_en !== 4'b0010 || ifa.bank_rd_addr[1*BAW +: BAW] !== 8'h01) begin
          errors++; $display("FAIL single_grant: ready=%b rd_en=%b addr1=%h, expected 0001/0010/01",
                             ifa.req_ready, ifa.bank_rd_en, ifa.bank_rd_addr[1*BAW +: BAW]);
        end
        qa.push_back('{0, 2'd2, mkdata(1, 8'h01), cyc + 1});
      end
      tick();
    end
  endtask

  task automatic test_conflict();
    logic [AW-1:0] addr [3];
    logic [NR-1:0] pending, exp_v;
    exp_t e;
    addr = '{10'h003, 10'h007, 10'h00B};
    pending = 4'b0111;
    for (int c = 0; c < 4; c++) begin
      clear_reqs();
      for (int i = 0; i < 3; i++) if (pending[i]) set_req(0, i, addr[i], OW'(i + 1));
      #2;
      exp_v = '0;
      while (qa.size() > 0 && qa[0].due == cyc) begin
        e = qa.pop_front();
        exp_v[e.rid] = 1'b1;
        checks++;
        if (ifa.rsp_opd_id[e.rid*OW +: OW] !== e.opd || ifa.rsp_data[e.rid*DW +: DW] !== e.data) begin
          errors++; $display("FAIL conflict_rsp r%0d: opd=%0d data=%h, expected opd=%0d data=%h", e.rid,
                             ifa.rsp_opd_id[e.rid*OW +: OW], ifa.rsp_data[e.rid*DW +: DW], e.opd, e.data);
        end
      end
      checks++;
      if (ifa.rsp_valid !== exp_v) begin
        errors++; $display("FAIL conflict_rsp_valid c%0d: got %b, expected %b", c, ifa.rsp_valid, exp_v);
      end
      if (c < 3) begin
        checks++;
        if (ifa.req_ready !== NR'(1 << c) || ifa.bank_rd_en !== 4'b1000 || ifa.bank_rd_addr[3*BAW +: BAW] !== BAW'(c)) begin
          errors++; $display("FAIL conflict_grant c%0d: ready=%b rd_en=%b addr3=%h, expected %b/1000/%h", c,
                             ifa.req_ready, ifa.bank_rd_en, ifa.bank_rd_addr[3*BAW +: BAW], NR'(1 << c), BAW'(c));
        end
        qa.push_back('{c, OW'(c + 1), mkdata(3, addr[c][9:2]), cyc + 1});
        pending[c] = 1'b0;
      end
      tick();
    end
    checks++;
    if (perf_a !== 32'd2) begin
      errors++; $display("FAIL conflict_perf: got %0d, expected 2", perf_a);
    end
  endtask

  task automatic test_parallel();
    logic [AW-1:0] addr [NR];
    logic [OW-1:0] opd [NR];
    logic [NR-1:0] exp_v;
    exp_t e;
    addr = '{10'h0A2, 10'h0B3, 10'h0C0, 10'h0D1};
    opd  = '{2'd3, 2'd0, 2'd1, 2'd2};
    for (int c = 0; c < 2; c++) begin
      clear_reqs();
      if (c == 0) for (int i = 0; i < NR; i++) set_req(0, i, addr[i], opd[i]);
      #2;
      exp_v = '0;
      while (qa.size() > 0 && qa[0].due == cyc) begin
        e = qa.pop_front();
        exp_v[e.rid] = 1'b1;
        checks++;
        if (ifa.rsp_opd_id[e.rid*OW +: OW] !== e.opd || ifa.rsp_data[e.rid*DW +: DW] !== e.data) begin
          errors++; $display("FAIL parallel_rsp r%0d: opd=%0d data=%h, expected opd=%0d data=%h", e.rid,
                             ifa.rsp_opd_id[e.rid*OW +: OW], ifa.rsp_data[e.rid*DW +: DW], e.opd, e.data);
        end
      end
      checks++;
      if (ifa.rsp_valid !== exp_v) begin
        errors++; $display("FAIL parallel_rsp_valid: got %b, expected %b", ifa.rsp_valid, exp_v);
      end
      if (c == 0) begin
        checks++;
        if (ifa.req_ready !== 4'b1111 || ifa.bank_rd_en !== 4'b1111) begin
          errors++; $display("FAIL parallel_grant: ready=%b rd_en=%b, expected 1111/1111", ifa.req_ready, ifa.bank_rd_en);
        end
        for (int i = 0; i < NR; i++) begin
          checks++;
          if (ifa.bank_rd_addr[int'(addr[i][1:0])*BAW +: BAW] !== addr[i][9:2]) begin
            errors++; $display("FAIL parallel_addr b%0d: got %h, expected %h", addr[i][1:0],
                               ifa.bank_rd_addr[int'(addr[i][1:0])*BAW +: BAW], addr[i][9:2]);
          end
          qa.push_back('{i, opd[i], mkdata(int'(addr[i][1:0]), addr[i][9:2]), cyc + 1});
        end
      end
      tick();
    end
    checks++;
    if (perf_a !== 32'd2) begin
      errors++; $display("FAIL parallel_perf: got %0d, expected 2", perf_a);
    end
  endtask

  // ptr[2] is 1 on entry; a lone grant to req 2 moves it to 3 before the wrap case.
  task automatic test_wrap();
    logic [AW-1:0] addr [NR];
    logic [OW-1:0] opd [NR];
    logic [NR-1:0] vmask [3];
    int            gnt [3];
    logic [NR-1:0] exp_v;
    exp_t e;
    addr  = '{10'h012, 10'h000, 10'h0E6, 10'h01E};
    opd   = '{2'd2, 2'd0, 2'd1, 2'd3};
    vmask = '{4'b0100, 4'b1001, 4'b0001};
    gnt   = '{2, 3, 0};
    for (int c = 0; c < 4; c++) begin
      clear_reqs();
      if (c < 3) for (int i = 0; i < NR; i++) if (vmask[c][i]) set_req(0, i, addr[i], opd[i]);
      #2;
      exp_v = '0;
      while (qa.size() > 0 && qa[0].due == cyc) begin
        e = qa.pop_front();
        exp_v[e.rid] = 1'b1;
        checks++;
        if (ifa.rsp_opd_id[e.rid*OW +: OW] !== e.opd || ifa.rsp_data[e.rid*DW +: DW] !== e.data) begin
          errors++; $display("FAIL wrap_rsp r%0d: opd=%0d data=%h, expected opd=%0d data=%h", e.rid,
                             ifa.rsp_opd_id[e.rid*OW +: OW], ifa.rsp_data[e.rid*DW +: DW], e.opd, e.data);
        end
      end
      checks++;
      if (ifa.rsp_valid !== exp_v) begin
        errors++; $display("FAIL wrap_rsp_valid c%0d: got %b, expected %b", c, ifa.rsp_valid, exp_v);
      end
      if (c < 3) begin
        checks++;
        if (ifa.req_ready !== NR'(1 << gnt[c]) || ifa.bank_rd_en !== 4'b0100 ||
            ifa.bank_rd_addr[2*BAW +: BAW] !== addr[gnt[c]][9:2]) begin
          errors++; $display("FAIL wrap_grant c%0d: ready=%b rd_en=%b addr2=%h, expected %b/0100/%h", c,
                             ifa.req_ready, ifa.bank_rd_en, ifa.bank_rd_addr[2*BAW +: BAW],
                             NR'(1 << gnt[c]), addr[gnt[c]][9:2]);
        end
        qa.push_back('{gnt[c], opd[gnt[c]], mkdata(2, addr[gnt[c]][9:2]), cyc + 1});
      end
      tick();
    end
    checks++;
    if (perf_a !== 32'd3) begin
      errors++; $display("FAIL wrap_perf: got %0d, expected 3", perf_a);
    end
  endtask

  task automatic test_latency3();
    logic [AW-1:0] addr [3];
    logic [NR-1:0] exp_v;
    exp_t e;
    addr = '{10'h011, 10'h026, 10'h03B};
    for (int c = 0; c < 7; c++) begin
      clear_reqs();
      if (c < 3) set_req(1, 1, addr[c], OW'(c + 1));
      #2;
      exp_v = '0;
      while (qb.size() > 0 && qb[0].due == cyc) begin
        e = qb.pop_front();
        exp_v[e.rid] = 1'b1;
        checks++;
        if (ifb.rsp_opd_id[e.rid*OW +: OW] !== e.opd || ifb.rsp_data[e.rid*DW +: DW] !== e.data) begin
          errors++; $display("FAIL lat3_rsp r%0d: opd=%0d data=%h, expected opd=%0d data=%h", e.rid,
                             ifb.rsp_opd_id[e.rid*OW +: OW], ifb.rsp_data[e.rid*DW +: DW], e.opd, e.data);
        end
      end
      checks++;
      if (ifb.rsp_valid !== exp_v) begin
        errors++; $display("FAIL lat3_rsp_valid c%0d: got %b, expected %b", c, ifb.rsp_valid, exp_v);
      end
      if (c < 3) begin
        checks++;
        if (ifb.req_ready !== 4'b0010 || ifb.bank_rd_en !== NB'(1 << addr[c][1:0])) begin
          errors++; $display("FAIL lat3_grant c%0d: ready=%b rd_en=%b, expected 0010/%b", c,
                             ifb.req_ready, ifb.bank_rd_en, NB'(1 << addr[c][1:0]));
        end
        qb.push_back('{1, OW'(c + 1), mkdata(int'(addr[c][1:0]), addr[c][9:2]), cyc + 3});
      end
      tick();
    end
  endtask

  // Read from req 2 in flight when reset hits; afterwards ptr[1]=0 must favour req 1 over req 3.
  task automatic test_reset_midflight();
    logic [NR-1:0] exp_v;
    exp_t e;
    for (int c = 0; c < 10; c++) begin
      clear_reqs();
      reset_b = (c == 1);
      if (c == 0) set_req(1, 2, 10'h0F5, 2'd2);
      if (c == 1 || c == 6) begin
        set_req(1, 1, 10'h009, 2'd1);
        set_req(1, 3, 10'h00D, 2'd3);
      end
      #2;
      exp_v = '0;
      while (qb.size() > 0 && qb[0].due == cyc) begin
        e = qb.pop_front();
        exp_v[e.rid] = 1'b1;
        checks++;
        if (ifb.rsp_opd_id[e.rid*OW +: OW] !== e.opd || ifb.rsp_data[e.rid*DW +: DW] !== e.data) begin
          errors++; $display("FAIL rstmid_rsp r%0d: opd=%0d data=%h, expected opd=%0d data=%h", e.rid,
                             ifb.rsp_opd_id[e.rid*OW +: OW], ifb.rsp_data[e.rid*DW +: DW], e.opd, e.data);
        end
      end
      checks++;
      if (ifb.rsp_valid !== exp_v) begin
        errors++; $display("FAIL rstmid_rsp_valid c%0d: got %b, expected %b", c, ifb.rsp_valid, exp_v);
      end
      if (c == 0) begin
        checks++;
        if (ifb.req_ready !== 4'b0100) begin
          errors++; $display("FAIL rstmid_first_grant: got %b, expected 0100", ifb.req_ready);
        end
      end
      if (c == 1) begin
        checks++;
        if (ifb.req_ready !== 4'b0000 || ifb.bank_rd_en !== 4'b0000) begin
          errors++; $display("FAIL rstmid_gate: ready=%b rd_en=%b, expected 0000/0000", ifb.req_ready, ifb.bank_rd_en);
        end
      end
      if (c == 6) begin
        checks++;
        if (ifb.req_ready !== 4'b0010 || ifb.bank_rd_addr[1*BAW +: BAW] !== 8'h02) begin
          errors++; $display("FAIL rstmid_ptr: ready=%b addr1=%h, expected 0010/02", ifb.req_ready,
                             ifb.bank_rd_addr[1*BAW +: BAW]);
        end
        qb.push_back('{1, 2'd1, mkdata(1, 8'h02), cyc + 3});
      end
      tick();
    end
    reset_b = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d, expected completion", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset_a = 1'b1;
    reset_b = 1'b1;
    clear_reqs();
    test_reset();
    test_single();
    test_conflict();
    test_parallel();
    test_wrap();
    test_latency3();
    test_reset_midflight();
    checks++;
    if (qa.size() != 0 || qb.size() != 0) begin
      errors++; $display("FAIL scoreboard_drain: pending a=%0d b=%0d, expected 0/0", qa.size(), qb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
